// File: rtl/axi_lite_rd_master.sv
// ---------------------------------------------------------------------------
// axi_lite_rd_master
//
// AXI-lite read-channel initiator. A core unit (IFU/LSU) hands over one
// single-beat read request at a time. The block drives AR, collects the R
// beat and returns data plus a status code on a valid/ready response port.
// Misaligned requests are answered locally with no bus access. A per-phase
// watchdog ends a transaction that the slave does not complete.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   req_valid     in   core read request valid
//   req_ready     out  high only while idle
//   req_addr      in   request byte address (ADDR_W)
//   resp_valid    out  response valid
//   resp_ready    in   core accepts response
//   resp_data     out  read data (DATA_W), zero on local errors
//   resp_err      out  any non-OKAY outcome
//   resp_code     out  00 OKAY, 10 SLVERR/DECERR, 01 misaligned, 11 timeout
//   araddr        out  AXI read address
//   arvalid       out  AXI read address valid
//   arready       in   AXI read address ready
//   rdata         in   AXI read data
//   rresp         in   AXI read response
//   rvalid        in   AXI read data valid
//   rready        out  AXI read data ready
//
// Every output is either a register or a decode of the state register, so
// no input reaches an output combinationally.
// ---------------------------------------------------------------------------
module axi_lite_rd_master #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 64,
    parameter int TIMEOUT     = 256,
    parameter int ALIGN_CHECK = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic [1:0]        resp_code,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready
);

    localparam logic [1:0] CODE_OKAY     = 2'b00;
    localparam logic [1:0] CODE_MISALIGN = 2'b01;
    localparam logic [1:0] CODE_BUSERR   = 2'b10;
    localparam logic [1:0] CODE_TIMEOUT  = 2'b11;

    // The counter only has to reach TIMEOUT-1.
    localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_RESP
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg,  addr_next;
    logic [DATA_W-1:0] data_reg,  data_next;
    logic [1:0]        code_reg,  code_next;
    logic              err_reg,   err_next;
    logic [CNT_W-1:0]  cnt_reg,   cnt_next;

    logic              expired;
    logic              misaligned;
    logic [1:0]        bus_code;

    // Watchdog expiry: the current cycle is the last one allowed in S_AR/S_R.
    generate
        if (TIMEOUT > 0) begin : g_timeout
            assign expired = (cnt_reg == CNT_LAST);
        end else begin : g_no_timeout
            assign expired = 1'b0;
        end
    endgenerate

    assign misaligned = (ALIGN_CHECK != 0) && (req_addr[2:0] != 3'b000);

    // EXOKAY carries no meaning for a single-beat initiator; fold it into OKAY.
    always_comb begin
        bus_code = CODE_BUSERR;
        case (rresp)
            2'b00, 2'b01: bus_code = CODE_OKAY;
            default:      bus_code = CODE_BUSERR;
        endcase
    end

    // -----------------------------------------------------------------------
    // State register and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            addr_reg  <= '0;
            data_reg  <= '0;
            code_reg  <= CODE_OKAY;
            err_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            data_reg  <= data_next;
            code_reg  <= code_next;
            err_reg   <= err_next;
            cnt_reg   <= cnt_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath update
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        data_next  = data_reg;
        code_next  = code_reg;
        err_next   = err_reg;
        cnt_next   = cnt_reg;

        case (state_reg)
            S_IDLE: begin
                if (req_valid) begin
                    addr_next = req_addr;
                    cnt_next  = '0;
                    if (misaligned) begin
                        data_next  = '0;
                        code_next  = CODE_MISALIGN;
                        err_next   = 1'b1;
                        state_next = S_RESP;
                    end else begin
                        state_next = S_AR;
                    end
                end
            end

            S_AR: begin
                // A handshake in the expiry cycle takes priority.
                if (arready) begin
                    cnt_next   = '0;
                    state_next = S_R;
                end else if (expired) begin
                    cnt_next   = '0;
                    data_next  = '0;
                    code_next  = CODE_TIMEOUT;
                    err_next   = 1'b1;
                    state_next = S_RESP;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            S_R: begin
                if (rvalid) begin
                    cnt_next   = '0;
                    data_next  = rdata;
                    code_next  = bus_code;
                    err_next   = (bus_code != CODE_OKAY);
                    state_next = S_RESP;
                end else if (expired) begin
                    cnt_next   = '0;
                    data_next  = '0;
                    code_next  = CODE_TIMEOUT;
                    err_next   = 1'b1;
                    state_next = S_RESP;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            S_RESP: begin
                if (resp_ready) begin
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs: decodes of the state register and register copies
    // -----------------------------------------------------------------------
    assign req_ready  = (state_reg == S_IDLE);
    assign arvalid    = (state_reg == S_AR);
    assign rready     = (state_reg == S_R);
    assign resp_valid = (state_reg == S_RESP);
    assign araddr     = addr_reg;
    assign resp_data  = data_reg;
    assign resp_code  = code_reg;
    assign resp_err   = err_reg;

endmodule

// File: tb/tb_axi_lite_rd_master.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_rd_master
//
// Drives read requests into axi_lite_rd_master and acts as the AXI slave with
// chosen arready/rvalid delays. For each request the expected response
// (data, code, latency) is derived from the delays and the response rules and
// queued; an independent monitor pops and compares whenever resp_valid is up.
// ---------------------------------------------------------------------------
module tb_axi_lite_rd_master;

    localparam int TMO = 8;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic        resp_err;
    logic [1:0]  resp_code;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    axi_lite_rd_master #(
        .ADDR_W(32),
        .DATA_W(64),
        .TIMEOUT(TMO),
        .ALIGN_CHECK(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr(req_addr),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data(resp_data),
        .resp_err(resp_err),
        .resp_code(resp_code),
        .araddr(araddr),
        .arvalid(arvalid),
        .arready(arready),
        .rdata(rdata),
        .rresp(rresp),
        .rvalid(rvalid),
        .rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  code;
        int          lat;
        int          t0;
        int          hold;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        errors++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // -----------------------------------------------------------------------
    // One transaction: model the expected outcome, issue, play the slave.
    // -----------------------------------------------------------------------
    task automatic do_req(input logic [31:0] addr, input int ar_d, input int r_d,
                          input logic [63:0] data, input logic [1:0] rr,
                          input int hold, input bit rst_in_r);
        exp_t e;
        bit   mis;
        int   arc;
        int   rc;
        int   k;
        int   n;

        mis    = (addr[2:0] != 3'b000);
        e.hold = hold;
        e.data = '0;
        arc    = 0;
        rc     = 0;
        if (mis) begin
            e.code = 2'b01;
        end else if (ar_d >= TMO) begin
            e.code = 2'b11;
            arc    = TMO;
        end else begin
            arc = ar_d + 1;
            if (r_d >= TMO) begin
                e.code = 2'b11;
                rc     = TMO;
            end else begin
                rc     = r_d + 1;
                e.code = rr[1] ? 2'b10 : 2'b00;
                e.data = data;
            end
        end
        e.lat = mis ? 1 : 1 + arc + rc;

        n = 0;
        while (!req_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            fail("req_ready_wait", {63'd0, req_ready}, 64'd1);
            return;
        end

        req_valid = 1'b1;
        req_addr  = addr;
        e.t0      = cyc;
        if (!rst_in_r) q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;

        if (!mis) begin
            k = 0;
            while (arvalid && k < 64) begin
                chk("araddr", {32'd0, araddr}, {32'd0, addr});
                chk("req_ready_busy_ar", {63'd0, req_ready}, 64'd0);
                arready = (k == ar_d);
                rvalid  = 1'($urandom_range(0, 1));
                rdata   = {$urandom, $urandom};
                rresp   = 2'($urandom);
                @(posedge clk);
                @(negedge clk);
                k++;
            end
            arready = 1'b0;
            rvalid  = 1'b0;
            chk("ar_cycles", 64'(k), 64'(arc));

            k = 0;
            while (rready && k < 64) begin
                chk("req_ready_busy_r", {63'd0, req_ready}, 64'd0);
                if (rst_in_r) begin
                    rst = 1'b1;
                    @(posedge clk);
                    @(negedge clk);
                    rst = 1'b0;
                    chk("rst_arvalid", {63'd0, arvalid}, 64'd0);
                    chk("rst_rready", {63'd0, rready}, 64'd0);
                    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
                    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
                    break;
                end
                rvalid = (k == r_d);
                rdata  = (k == r_d) ? data : {$urandom, $urandom};
                rresp  = (k == r_d) ? rr : 2'($urandom);
                @(posedge clk);
                @(negedge clk);
                k++;
            end
            rvalid = 1'b0;
            if (!rst_in_r) chk("r_cycles", 64'(k), 64'(rc));
        end

        n = 0;
        while (!req_ready && n < 500) begin
            if (mis) chk("arvalid_misaligned", {63'd0, arvalid}, 64'd0);
            @(negedge clk);
            n++;
        end
        if (!req_ready) fail("resp_drain", {63'd0, req_ready}, 64'd1);
    endtask

    // -----------------------------------------------------------------------
    // Response monitor: pops the scoreboard and randomises resp_ready.
    // -----------------------------------------------------------------------
    bit   mon_busy = 1'b0;
    bit   mon_prev_rr = 1'b0;
    int   mon_hold = 0;
    exp_t cur;

    initial begin
        resp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_busy    = 1'b0;
                mon_prev_rr = 1'b0;
                resp_ready  = 1'b0;
            end else begin
                if (mon_busy && mon_prev_rr) mon_busy = 1'b0;
                if (resp_valid) begin
                    if (!mon_busy) begin
                        if (q.size() == 0) begin
                            fail("unexpected_resp", resp_data, 64'd0);
                        end else begin
                            cur      = q.pop_front();
                            mon_busy = 1'b1;
                            mon_hold = cur.hold;
                            chk("latency", 64'(cyc - cur.t0), 64'(cur.lat));
                        end
                    end
                    if (mon_busy) begin
                        chk("resp_data", resp_data, cur.data);
                        chk("resp_code", {62'd0, resp_code}, {62'd0, cur.code});
                        chk("resp_err", {63'd0, resp_err}, {63'd0, (cur.code != 2'b00)});
                    end
                    if (mon_hold > 0) begin
                        resp_ready = 1'b0;
                        mon_hold--;
                    end else begin
                        resp_ready = ($urandom_range(0, 3) != 0);
                    end
                end else begin
                    if (mon_busy) fail("resp_valid_dropped", 64'd0, 64'd1);
                    mon_busy   = 1'b0;
                    resp_ready = 1'($urandom_range(0, 1));
                end
                mon_prev_rr = resp_ready;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        logic [31:0] a;
        int          ard;
        int          rd;
        int          n;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        arready   = 1'b0;
        rvalid    = 1'b0;
        rdata     = '0;
        rresp     = 2'b00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_arvalid", {63'd0, arvalid}, 64'd0);
        chk("reset_rready", {63'd0, rready}, 64'd0);
        chk("reset_araddr", {32'd0, araddr}, 64'd0);
        chk("reset_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("reset_resp_data", resp_data, 64'd0);
        chk("reset_resp_err", {63'd0, resp_err}, 64'd0);
        chk("reset_resp_code", {62'd0, resp_code}, 64'd0);
        chk("reset_req_ready", {63'd0, req_ready}, 64'd1);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        do_req(32'h8000_0008, 0, 0, 64'h1122_3344_5566_7788, 2'b00, 0, 1'b0);
        do_req(32'h8000_0010, 5, 3, 64'hA5A5_0000_FFFF_1234, 2'b00, 0, 1'b0);
        do_req(32'h8000_0018, 1, 2, 64'hDEAD_BEEF_CAFE_F00D, 2'b10, 0, 1'b0);
        do_req(32'h8000_0004, 0, 0, 64'h1, 2'b00, 0, 1'b0);
        do_req(32'h8000_0020, 20, 0, 64'h2, 2'b00, 0, 1'b0);

        // Stray rvalid while idle must not start anything
        rvalid = 1'b1;
        rdata  = 64'h0BAD_0BAD_0BAD_0BAD;
        repeat (3) begin
            @(negedge clk);
            chk("stray_rready", {63'd0, rready}, 64'd0);
            chk("stray_req_ready", {63'd0, req_ready}, 64'd1);
        end
        rvalid = 1'b0;

        do_req(32'h8000_0028, 0, 0, 64'h0123_4567_89AB_CDEF, 2'b01, 0, 1'b0);
        do_req(32'h8000_0030, 1, 20, 64'h3, 2'b00, 0, 1'b0);
        do_req(32'h8000_0038, 7, 7, 64'h4444_5555_6666_7777, 2'b11, 0, 1'b0);
        do_req(32'h8000_0040, 0, 8, 64'h5, 2'b00, 0, 1'b0);
        do_req(32'h8000_0048, 0, 5, 64'h6, 2'b00, 0, 1'b1);
        do_req(32'h8000_0050, 2, 1, 64'hFEDC_BA98_7654_3210, 2'b00, 4, 1'b0);

        // Randomised traffic
        for (int i = 0; i < 80; i++) begin
            a = $urandom;
            if ($urandom_range(0, 5) != 0) a[2:0] = 3'b000;
            ard = ($urandom_range(0, 9) == 0) ? $urandom_range(8, 11) : $urandom_range(0, 7);
            rd  = ($urandom_range(0, 9) == 0) ? $urandom_range(8, 11) : $urandom_range(0, 7);
            do_req(a, ard, rd, {$urandom, $urandom}, 2'($urandom),
                   ($urandom_range(0, 7) == 0) ? $urandom_range(1, 5) : 0, 1'b0);
        end

        n = 0;
        while ((q.size() != 0 || !req_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_rd_master.md
Name: axi_lite_rd_master

Overview:
AXI-lite read-channel initiator, the master end of the memory read slave.
- Accepts single-beat read requests from a core unit (IFU/LSU) on a valid/ready request port.
- Drives the AR channel, collects R data and returns data plus status on a valid/ready response port.
- One outstanding transaction at a time; timeout and misalignment errors are reported back to the core.

Parameters:
- ADDR_W, 32, address width (req_addr, araddr).
- DATA_W, 64, data width (rdata, resp_data).
- TIMEOUT, 256, maximum cycles spent in S_AR or S_R before error; 0 disables the timeout.
- ALIGN_CHECK, 1, when 1 a req_addr with bits [2:0] != 0 is rejected without a bus access.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  core read request valid
- req_ready  out  1  block can accept a request
- req_addr  in  ADDR_W  request byte address
- resp_valid  out  1  response valid
- resp_ready  in  1  core accepts response
- resp_data  out  DATA_W  read data
- resp_err  out  1  any non-OKAY outcome
- resp_code  out  2  00 OKAY, 10 bus SLVERR/DECERR (rresp), 01 misaligned, 11 timeout
- araddr  out  ADDR_W  AXI read address
- arvalid  out  1  AXI read address valid
- arready  in  1  AXI read address ready
- rdata  in  DATA_W  AXI read data
- rresp  in  2  AXI read response
- rvalid  in  1  AXI read data valid
- rready  out  1  AXI read data ready

Behaviour:
- All outputs are registered or decoded from the state register only. No combinational path from any input to any output.
- Reset values: state S_IDLE, arvalid 0, rready 0, araddr 0, resp_valid 0, resp_data 0, resp_err 0, resp_code 00, timeout counter 0.
- Reset asserted mid-transaction abandons the transaction immediately; no response is produced.
- req_ready = 1 only in S_IDLE.
- S_IDLE:
  - On req_valid: latch req_addr.
  - If ALIGN_CHECK and addr[2:0] != 0: go to S_RESP with code 01, data 0. No AR issued.
  - Otherwise: go to S_AR.
- S_AR:
  - arvalid = 1; araddr holds the latched address, stable until the handshake.
  - On arready: go to S_R and clear the counter.
- S_R:
  - rready = 1.
  - On rvalid: latch rdata into resp_data and rresp into resp_code. rresp 00 gives code 00; 10 or 11 gives code 10; 01 (EXOKAY) is treated as 00.
  - resp_err = (code != 00). Go to S_RESP.
- S_RESP:
  - resp_valid = 1; resp_data, resp_err and resp_code held stable.
  - On resp_ready: go to S_IDLE.
  - A new request is accepted no earlier than the cycle after resp_ready.
- Timeout (TIMEOUT > 0):
  - The counter increments each cycle in S_AR or S_R without the relevant handshake.
  - When the counter reaches TIMEOUT-1 with no handshake that cycle: go to S_RESP with code 11, data 0; arvalid and rready deassert.
  - A handshake arriving in the same cycle as expiry wins; the normal path is taken.
- Stray rvalid outside S_R is ignored, since rready = 0 there.
- Latency with a zero-wait slave:
  - Request accepted at cycle 0; arvalid high in cycle 1.
  - arready in cycle 1 puts rready high in cycle 2.
  - rvalid in cycle 2 raises resp_valid in cycle 3.
  - Minimum 3 cycles from request handshake to resp_valid.
- resp_ready held high in S_RESP: resp_valid is high for exactly one cycle.

Test Plan:
1. Zero-wait slave; req_addr=0x80000008; rdata=0x1122334455667788, rresp=00 in cycle 2 -> resp_valid in cycle 3, resp_data=0x1122334455667788, resp_err=0, code=00.
2. arready delayed 5 cycles and rvalid delayed 3 cycles -> araddr stable at 0x80000010 with arvalid high throughout; resp_valid exactly 1 cycle after rvalid; req_ready=0 for the whole transaction.
3. rresp=10 on the returned beat -> resp_err=1, code=10, resp_data equals rdata.
4. req_addr=0x80000004 with ALIGN_CHECK=1 -> arvalid never asserted; resp_valid at cycle 1 with code=01.
5. TIMEOUT=8, arready held low -> arvalid high for 8 cycles then low; resp_valid with code=11, resp_data=0; a later stray rvalid is ignored and the next request completes normally.
6. rst asserted while in S_R, then resp_ready held low in S_RESP for 4 cycles -> reset yields arvalid=rready=resp_valid=0 and req_ready=1 next cycle; in S_RESP, resp_data/resp_code stay stable while resp_ready is low.
